// File: rtl/cond_issue_controller_pkg.sv
// Shared CPU definitions: ARM condition codes, NZCV bit positions and controller widths.
package cond_issue_controller_pkg;

  localparam int unsigned COND_W = 4;
  localparam int unsigned NZCV_W = 4;
  localparam int unsigned PEND_W = 3;

  localparam logic [COND_W-1:0] COND_EQ     = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE     = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS     = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC     = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI     = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL     = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS     = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC     = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI     = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS     = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE     = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT     = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT     = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE     = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL     = 4'b1110;
  localparam logic [COND_W-1:0] COND_UNPRED = 4'b1111;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/cond_issue_controller_evaluator.sv
// Conditional evaluator: decides whether an ARM condition field passes for a given NZCV value.
module conditional_evaluator
  import cond_issue_controller_pkg::*;
(
  input  logic [NZCV_W-1:0] flags,
  input  logic [COND_W-1:0] cond,
  output logic              pass_c
);

  logic n, z, c, v;

  assign n = flags[NZCV_N];
  assign z = flags[NZCV_Z];
  assign c = flags[NZCV_C];
  assign v = flags[NZCV_V];

  // Unpredictable encoding never executes.
  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_EQ: pass_c = z;
      COND_NE: pass_c = ~z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = ~c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = ~n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = ~v;
      COND_HI: pass_c = c & ~z;
      COND_LS: pass_c = ~c | z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = ~z & (n == v);
      COND_LE: pass_c = z | (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_controller.sv
// Issue-stage conditional execution controller: owns NZCV, interlocks on pending flag
// writers and hands a registered execute/squash decision to the execute stage.
module cond_issue_controller
  import cond_issue_controller_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_issue_valid,
  input  logic [COND_W-1:0] in_issue_cond,
  input  logic              in_issue_sets_flags,
  input  logic [TAG_W-1:0]  in_issue_tag,
  output logic              out_issue_ready,
  input  logic              in_flags_valid,
  input  logic [NZCV_W-1:0] in_flags_nzcv,
  output logic              out_exec_valid,
  output logic              out_exec_en,
  output logic [TAG_W-1:0]  out_exec_tag,
  input  logic              in_exec_ready,
  output logic [NZCV_W-1:0] out_cpsr,
  output logic [PEND_W-1:0] out_pending,
  output logic              out_wb_error
);

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING);

  logic [PEND_W-1:0] pending;
  logic [NZCV_W-1:0] cpsr;
  logic [NZCV_W-1:0] eff_flags;
  logic              cond_pass;
  logic              wb_ok;
  logic              hazard;
  logic              cap_stall;
  logic              slot_free;
  logic              accept;
  logic              pend_inc;

  conditional_evaluator u_eval (
    .flags  (eff_flags),
    .cond   (in_issue_cond),
    .pass_c (cond_pass)
  );

  // Issue gating; the last outstanding writer's flags are forwarded in its writeback cycle.
  always_comb begin
    wb_ok     = in_flags_valid && (pending != '0);
    eff_flags = (in_flags_valid && (pending == PEND_W'(1))) ? in_flags_nzcv : cpsr;
    hazard    = (in_issue_cond != COND_AL) &&
                ((pending > PEND_W'(1)) || ((pending == PEND_W'(1)) && !in_flags_valid));
    cap_stall = in_issue_sets_flags && (pending == MAX_P) && !in_flags_valid;
    slot_free = !out_exec_valid || in_exec_ready;
    out_issue_ready = slot_free && !hazard && !cap_stall;
    accept    = in_issue_valid && out_issue_ready;
    // Failed-condition flag setters never write NZCV, so they are not tracked.
    pend_inc  = accept && in_issue_sets_flags && cond_pass;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cpsr           <= '0;
      pending        <= '0;
      out_exec_valid <= 1'b0;
      out_exec_en    <= 1'b0;
      out_exec_tag   <= '0;
      out_wb_error   <= 1'b0;
    end else begin
      if (wb_ok) begin
        cpsr <= in_flags_nzcv;
      end else if (in_flags_valid) begin
        out_wb_error <= 1'b1;
      end

      case ({pend_inc, wb_ok})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase

      // Decision fields only move on accept, which requires a free slot.
      if (accept) begin
        out_exec_valid <= 1'b1;
        out_exec_en    <= cond_pass;
        out_exec_tag   <= in_issue_tag;
      end else if (in_exec_ready) begin
        out_exec_valid <= 1'b0;
      end
    end
  end

  assign out_cpsr    = cpsr;
  assign out_pending = pending;

endmodule

// File: tb/tb_cond_issue_controller.sv
// Randomized scoreboard bench for cond_issue_controller against a behavioural issue model.
module tb_cond_issue_controller;

  localparam int unsigned MAX_PENDING = 2;
  localparam int unsigned TAG_W       = 4;
  localparam int          N_CYCLES    = 4000;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [3:0]       issue_cond;
  logic             issue_sets_flags;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic             flags_valid;
  logic [3:0]       flags_nzcv;
  logic             exec_valid;
  logic             exec_en;
  logic [TAG_W-1:0] exec_tag;
  logic             exec_ready;
  logic [3:0]       cpsr;
  logic [2:0]       pending;
  logic             wb_error;

  cond_issue_controller #(.MAX_PENDING(MAX_PENDING), .TAG_W(TAG_W)) dut (
    .in_clk              (clk),
    .in_rst              (rst),
    .in_issue_valid      (issue_valid),
    .in_issue_cond       (issue_cond),
    .in_issue_sets_flags (issue_sets_flags),
    .in_issue_tag        (issue_tag),
    .out_issue_ready     (issue_ready),
    .in_flags_valid      (flags_valid),
    .in_flags_nzcv       (flags_nzcv),
    .out_exec_valid      (exec_valid),
    .out_exec_en         (exec_en),
    .out_exec_tag        (exec_tag),
    .in_exec_ready       (exec_ready),
    .out_cpsr            (cpsr),
    .out_pending         (pending),
    .out_wb_error        (wb_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state and its value after the coming edge.
  int       m_pend, n_pend;
  bit [3:0] m_cpsr, n_cpsr;
  bit       m_err, n_err, m_valid, n_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ARM condition: pairs share a predicate, odd codes invert it; 111x is AL / never.
  function automatic bit m_eval(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: return !c[0];
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_reset();
    n_pend = 0; n_cpsr = 4'b0; n_err = 1'b0; n_valid = 1'b0;
    q.delete();
  endtask

  // One cycle: commit model, check registered outputs, drive inputs, predict the edge.
  task automatic step(input bit drain);
    bit hazard, cap, rdy, acc, en, wb;
    bit [3:0] eff;
    @(posedge clk);
    #1;
    m_pend = n_pend; m_cpsr = n_cpsr; m_err = n_err; m_valid = n_valid;
    chk("cpsr", 32'(cpsr), 32'(m_cpsr));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("wb_error", 32'(wb_error), 32'(m_err));
    chk("exec_valid", 32'(exec_valid), 32'(m_valid));

    rst              = !drain && ($urandom_range(0, 199) == 0);
    issue_valid      = !drain && ($urandom_range(0, 99) < 75);
    issue_cond       = 4'($urandom_range(0, 15));
    issue_sets_flags = ($urandom_range(0, 1) == 1);
    issue_tag        = TAG_W'($urandom);
    if (m_pend > 0) flags_valid = ($urandom_range(0, 99) < 30);
    else            flags_valid = !drain && ($urandom_range(0, 99) < 3);
    flags_nzcv       = 4'($urandom);
    exec_ready       = !rst && (drain || ($urandom_range(0, 99) < 70));
    #1;

    if (rst) begin
      model_reset();
    end else begin
      hazard = (issue_cond != 4'b1110) && (m_pend > 1 || (m_pend == 1 && !flags_valid));
      cap    = issue_sets_flags && (m_pend == MAX_PENDING) && !flags_valid;
      rdy    = (!m_valid || exec_ready) && !hazard && !cap;
      chk("issue_ready", 32'(issue_ready), 32'(rdy));
      eff    = (flags_valid && m_pend == 1) ? flags_nzcv : m_cpsr;
      acc    = issue_valid && rdy;
      en     = acc && m_eval(issue_cond, eff);
      if (acc) q.push_back({en, issue_tag});
      wb     = flags_valid && m_pend > 0;
      n_pend = m_pend + ((acc && issue_sets_flags && en) ? 1 : 0) - (wb ? 1 : 0);
      n_cpsr = wb ? flags_nzcv : m_cpsr;
      n_err  = m_err || (flags_valid && m_pend == 0);
      n_valid = acc ? 1'b1 : (exec_ready ? 1'b0 : m_valid);
    end
  endtask

  // Monitor: a decision consumed this cycle must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (!rst && exec_valid && exec_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL exec_unexpected at %0t: got tag %0h expected no decision", $time, exec_tag);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("exec_en", 32'(exec_en), 32'(e.en));
        chk("exec_tag", 32'(exec_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_cond = 4'b0; issue_sets_flags = 1'b0;
    issue_tag = '0; flags_valid = 1'b1; flags_nzcv = 4'hF; exec_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpsr", 32'(cpsr), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_exec_valid", 32'(exec_valid), 32'd0);
    chk("rst_exec_en", 32'(exec_en), 32'd0);
    chk("rst_exec_tag", 32'(exec_tag), 32'd0);
    chk("rst_wb_error", 32'(wb_error), 32'd0);
    rst = 1'b0; flags_valid = 1'b0;

    for (int i = 0; i < N_CYCLES; i++) step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
